// File: rtl/issue_queue.sv
// Out-of-order issue queue: oldest-first select among operand-ready entries,
// multi-channel tag broadcast wakeup, flush and synchronous active-low reset.
module issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned N_WB  = 2,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned DAT_W = 32,
    parameter int unsigned OP_W  = 6,
    parameter int unsigned ADR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic                     in_ic,
    input  logic [ROB_W-1:0]         in_qj,
    input  logic [ROB_W-1:0]         in_qk,
    input  logic [DAT_W-1:0]         in_vj,
    input  logic [DAT_W-1:0]         in_vk,
    input  logic [ROB_W-1:0]         in_qd,
    input  logic [DAT_W-1:0]         in_imm,
    input  logic [ADR_W-1:0]         in_pc,
    input  logic [N_WB-1:0]          wb_en,
    input  logic [N_WB*ROB_W-1:0]    wb_q,
    input  logic [N_WB*DAT_W-1:0]    wb_v,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic [OP_W-1:0]          alu_op,
    output logic                     alu_ic,
    output logic [ROB_W-1:0]         alu_qd,
    output logic [DAT_W-1:0]         alu_vs,
    output logic [DAT_W-1:0]         alu_vt,
    output logic [DAT_W-1:0]         alu_imm,
    output logic [ADR_W-1:0]         alu_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic [DEPTH-1:0] busy_q;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic             ic_q  [DEPTH];
    logic [ROB_W-1:0] qj_q  [DEPTH];
    logic [ROB_W-1:0] qk_q  [DEPTH];
    logic [DAT_W-1:0] vj_q  [DEPTH];
    logic [DAT_W-1:0] vk_q  [DEPTH];
    logic [ROB_W-1:0] qd_q  [DEPTH];
    logic [DAT_W-1:0] imm_q [DEPTH];
    logic [ADR_W-1:0] pc_q  [DEPTH];
    // older_q[i][j] set means entry i was inserted before entry j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [CW-1:0]    count_q;

    logic [DEPTH-1:0] ready, sel;
    logic [IW-1:0]    sel_idx, ins_idx;
    logic [DAT_W:0]   wj [DEPTH];
    logic [DAT_W:0]   wk [DEPTH];
    logic [DAT_W:0]   in_wj, in_wk;
    logic             do_ins, do_iss;

    // Returns {hit, value}; lowest matching channel wins, tag 0 never matches.
    function automatic logic [DAT_W:0] wake(input logic [ROB_W-1:0] tag,
                                            input logic [N_WB-1:0] en,
                                            input logic [N_WB*ROB_W-1:0] q,
                                            input logic [N_WB*DAT_W-1:0] v);
        logic [DAT_W:0] r;
        r = '0;
        for (int c = N_WB - 1; c >= 0; c--) begin
            if (en[c] && tag != '0 && q[c*ROB_W +: ROB_W] == tag) begin
                r = {1'b1, v[c*DAT_W +: DAT_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
            wj[i]    = wake(qj_q[i], wb_en, wb_q, wb_v);
            wk[i]    = wake(qk_q[i], wb_en, wb_q, wb_v);
        end
        in_wj = wake(in_qj, wb_en, wb_q, wb_v);
        in_wk = wake(in_qk, wb_en, wb_q, wb_v);
    end

    always_comb begin
        sel     = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older_q[j][i]) sel[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) sel_idx = IW'(i);
        end
    end

    always_comb begin
        ins_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) ins_idx = IW'(i);
        end
    end

    assign alu_valid = |ready;
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign in_ready  = !full;
    assign count     = count_q;
    assign do_ins    = in_valid && in_ready;
    assign do_iss    = alu_valid && alu_ready;

    always_comb begin
        alu_op  = '0;
        alu_ic  = 1'b0;
        alu_qd  = '0;
        alu_vs  = '0;
        alu_vt  = '0;
        alu_imm = '0;
        alu_pc  = '0;
        if (alu_valid) begin
            alu_op  = op_q[sel_idx];
            alu_ic  = ic_q[sel_idx];
            alu_qd  = qd_q[sel_idx];
            alu_vs  = vj_q[sel_idx];
            alu_vt  = vk_q[sel_idx];
            alu_imm = imm_q[sel_idx];
            alu_pc  = pc_q[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= '0;
                ic_q[i]    <= 1'b0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qd_q[i]    <= '0;
                imm_q[i]   <= '0;
                pc_q[i]    <= '0;
                older_q[i] <= '0;
            end
        end else if (flush) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && wj[i][DAT_W]) begin
                    qj_q[i] <= '0;
                    vj_q[i] <= wj[i][DAT_W-1:0];
                end
                if (busy_q[i] && wk[i][DAT_W]) begin
                    qk_q[i] <= '0;
                    vk_q[i] <= wk[i][DAT_W-1:0];
                end
            end
            if (do_iss) busy_q[sel_idx] <= 1'b0;
            if (do_ins) begin
                busy_q[ins_idx] <= 1'b1;
                op_q[ins_idx]   <= in_op;
                ic_q[ins_idx]   <= in_ic;
                qd_q[ins_idx]   <= in_qd;
                imm_q[ins_idx]  <= in_imm;
                pc_q[ins_idx]   <= in_pc;
                qj_q[ins_idx]   <= in_wj[DAT_W] ? '0 : in_qj;
                vj_q[ins_idx]   <= in_wj[DAT_W] ? in_wj[DAT_W-1:0] : in_vj;
                qk_q[ins_idx]   <= in_wk[DAT_W] ? '0 : in_qk;
                vk_q[ins_idx]   <= in_wk[DAT_W] ? in_wk[DAT_W-1:0] : in_vk;
                for (int j = 0; j < DEPTH; j++) begin
                    older_q[j][ins_idx] <= busy_q[j];
                end
                older_q[ins_idx] <= '0;
            end
            count_q <= count_q + CW'(do_ins) - CW'(do_iss);
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an age-ordered queue model.
module tb_issue_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_ic, alu_valid, alu_ready, alu_ic;
    logic [5:0]  in_op, alu_op;
    logic [3:0]  in_qj, in_qk, in_qd, alu_qd;
    logic [31:0] in_vj, in_vk, in_imm, in_pc;
    logic [31:0] alu_vs, alu_vt, alu_imm, alu_pc;
    logic [1:0]  wb_en;
    logic [7:0]  wb_q;
    logic [63:0] wb_v;
    logic [3:0]  count;
    logic        full, empty;

    int n_checks = 0;
    int n_fail   = 0;

    issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_ic(in_ic), .in_qj(in_qj), .in_qk(in_qk), .in_vj(in_vj),
        .in_vk(in_vk), .in_qd(in_qd), .in_imm(in_imm), .in_pc(in_pc), .wb_en(wb_en),
        .wb_q(wb_q), .wb_v(wb_v), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_op(alu_op), .alu_ic(alu_ic), .alu_qd(alu_qd), .alu_vs(alu_vs), .alu_vt(alu_vt),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        ic;
        logic [3:0]  qj, qk, qd;
        logic [31:0] vj, vk, imm, pc;
    } ent_t;

    ent_t mq[$];  // oldest at index 0

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] m_wake(input logic [3:0] tag);
        if (tag == 4'd0) return 33'd0;
        for (int c = 0; c < 2; c++) begin
            if (wb_en[c] && wb_q[c*4 +: 4] == tag) return {1'b1, wb_v[c*32 +: 32]};
        end
        return 33'd0;
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].qj == 4'd0 && mq[i].qk == 4'd0) return i;
        end
        return -1;
    endfunction

    // Reference model update at each rising edge.
    always @(posedge clk) begin
        int s;
        bit iss, ins;
        ent_t e;
        logic [32:0] w;
        if (!rst || flush) begin
            mq.delete();
        end else begin
            s   = m_sel();
            iss = (s >= 0) && alu_ready;
            ins = in_valid && (mq.size() < 8);
            for (int i = 0; i < mq.size(); i++) begin
                w = m_wake(mq[i].qj);
                if (w[32]) begin mq[i].qj = 4'd0; mq[i].vj = w[31:0]; end
                w = m_wake(mq[i].qk);
                if (w[32]) begin mq[i].qk = 4'd0; mq[i].vk = w[31:0]; end
            end
            if (iss) mq.delete(s);
            if (ins) begin
                e.op = in_op; e.ic = in_ic; e.qd = in_qd; e.imm = in_imm; e.pc = in_pc;
                e.qj = in_qj; e.vj = in_vj; e.qk = in_qk; e.vk = in_vk;
                w = m_wake(in_qj);
                if (w[32]) begin e.qj = 4'd0; e.vj = w[31:0]; end
                w = m_wake(in_qk);
                if (w[32]) begin e.qk = 4'd0; e.vk = w[31:0]; end
                mq.push_back(e);
            end
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        int s;
        s = m_sel();
        chk("alu_valid", alu_valid, s >= 0);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == 8);
        chk("empty", empty, mq.size() == 0);
        chk("in_ready", in_ready, mq.size() < 8);
        if (s >= 0) begin
            chk("alu_op", alu_op, mq[s].op);
            chk("alu_ic", alu_ic, mq[s].ic);
            chk("alu_qd", alu_qd, mq[s].qd);
            chk("alu_vs", alu_vs, mq[s].vj);
            chk("alu_vt", alu_vt, mq[s].vk);
            chk("alu_imm", alu_imm, mq[s].imm);
            chk("alu_pc", alu_pc, mq[s].pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                       input logic [31:0] vj, input logic [31:0] vk);
        in_valid = 1'b1;
        in_op    = op;
        in_ic    = op[0];
        in_qj    = qj;
        in_qk    = qk;
        in_vj    = vj;
        in_vk    = vk;
        in_qd    = op[3:0];
        in_imm   = {26'd0, op} + 32'h100;
        in_pc    = {26'd0, op} + 32'h4000;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_alu_valid"}, alu_valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_alu_vs"}, alu_vs, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; alu_ready = 1'b0;
        wb_en = '0; wb_q = '0; wb_v = '0;
        ins(6'd0, 4'd0, 4'd0, 32'd0, 32'd0);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk_reset_vals("reset");

        // Single ready op issues one cycle after insert
        ins(6'h11, 4'd0, 4'd0, 32'hA, 32'hB);
        alu_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_valid", alu_valid, 1);
        chk("single_op", alu_op, 6'h11);
        chk("single_vs", alu_vs, 32'hA);
        chk("single_count", count, 1);
        tick();
        chk("single_drained", count, 0);
        alu_ready = 1'b0;

        // Oldest-ready selection with wakeup of the oldest entry
        ins(6'd1, 4'd3, 4'd0, 32'd0, 32'd0); tick();
        ins(6'd2, 4'd0, 4'd0, 32'd0, 32'd0); tick();
        ins(6'd3, 4'd0, 4'd0, 32'd0, 32'd0); tick();
        in_valid = 1'b0;
        chk("age_shows_b", alu_op, 6'd2);
        wb_en = 2'b01; wb_q = {4'd0, 4'd3}; wb_v = {32'd0, 32'h55};
        tick();
        wb_en = 2'b00;
        chk("age_a_first", alu_op, 6'd1);
        chk("age_a_vs", alu_vs, 32'h55);
        alu_ready = 1'b1;
        tick(); chk("age_b_second", alu_op, 6'd2);
        tick(); chk("age_c_third", alu_op, 6'd3);
        tick(); chk("age_empty", empty, 1);
        alu_ready = 1'b0;

        // Fill to full, overflow ignored, broadcast on channel 1 wakes all
        for (int i = 0; i < 8; i++) begin
            ins(6'(i), 4'd5, 4'd0, 32'd0, 32'd0);
            tick();
        end
        chk("fill_full", full, 1);
        chk("fill_in_ready", in_ready, 0);
        ins(6'h3F, 4'd0, 4'd0, 32'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("fill_count", count, 8);
        wb_en = 2'b10; wb_q = {4'd5, 4'd0}; wb_v = {32'h77, 32'd0};
        tick();
        wb_en = 2'b00;
        alu_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_order", alu_op, i);
            chk("fill_vs", alu_vs, 32'h77);
            tick();
        end
        chk("fill_drained", count, 0);
        alu_ready = 1'b0;

        // Wakeup of the entry being inserted
        ins(6'd9, 4'd0, 4'd7, 32'd0, 32'd0);
        wb_en = 2'b01; wb_q = {4'd0, 4'd7}; wb_v = {32'd0, 32'h1234};
        tick();
        in_valid = 1'b0;
        wb_en = 2'b00;
        chk("insw_valid", alu_valid, 1);
        chk("insw_vt", alu_vt, 32'h1234);
        alu_ready = 1'b1;
        tick();
        chk("insw_empty", empty, 1);
        alu_ready = 1'b0;

        // Flush, then reset, each with concurrent insert and issue
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                ins(6'(i + 1), 4'd0, 4'd0, 32'(i), 32'(i));
                tick();
            end
            if (r == 0) flush = 1'b1; else rst = 1'b0;
            alu_ready = 1'b1;
            tick();
            flush = 1'b0; rst = 1'b1; in_valid = 1'b0; alu_ready = 1'b0;
            chk_reset_vals(r == 0 ? "flush" : "midrst");
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = $urandom_range(0, 99) < 60;
            in_op     = 6'($urandom);
            in_ic     = 1'($urandom);
            in_qj     = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
            in_qk     = $urandom_range(0, 2) != 0 ? 4'd0 : 4'($urandom_range(1, 15));
            in_vj     = $urandom;
            in_vk     = $urandom;
            in_qd     = 4'($urandom);
            in_imm    = $urandom;
            in_pc     = $urandom;
            wb_en     = 2'($urandom);
            wb_q[3:0] = 4'($urandom_range(0, 15));
            wb_q[7:4] = $urandom_range(0, 3) == 0 ? wb_q[3:0] : 4'($urandom_range(0, 15));
            wb_v      = {$urandom, $urandom};
            alu_ready = $urandom_range(0, 99) < 45;
            flush     = $urandom_range(0, 99) == 0;
            rst       = $urandom_range(0, 199) != 0;
            tick();
        end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_en = '0; alu_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entry count, power of two, >= 2.
REQ-002 SHALL have parameter N_WB, default 2: number of parallel wakeup (broadcast) channels, >= 1.
REQ-003 SHALL have parameters ROB_W=4 (tag width), DAT_W=32, OP_W=6, ADR_W=32.
REQ-004 Port list. One clock; reset is synchronous and active-low:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-low reset (0 = reset)
- flush  input  1  branch-mispredict flush
- in_valid  input  1  dispatch request
- in_ready  output  1  queue can accept
- in_op  input  OP_W  opcode
- in_ic  input  1  0 = I-type, 1 = C-type
- in_qj, in_qk  input  ROB_W each  source tags, 0 = operand present
- in_vj, in_vk  input  DAT_W each  source values
- in_qd  input  ROB_W  destination ROB tag
- in_imm  input  DAT_W  immediate
- in_pc  input  ADR_W  instruction PC
- wb_en  input  N_WB  per-channel broadcast valid
- wb_q  input  N_WB*ROB_W  per-channel tag, channel c at bits [c*ROB_W +: ROB_W]
- wb_v  input  N_WB*DAT_W  per-channel value, same packing
- alu_valid  output  1  selected entry offered
- alu_ready  input  1  ALU accepts
- alu_op, alu_ic, alu_qd, alu_vs, alu_vt, alu_imm, alu_pc  output  widths as inputs  selected entry fields
- count  output  clog2(DEPTH)+1  occupied entries
- full, empty  output  1  count==DEPTH / count==0

Function
REQ-005 Entry ready = busy && qj==0 && qk==0, evaluated on registered state only.
REQ-006 alu_valid SHALL be 1 iff at least one entry is ready; alu_* fields SHALL be combinational from the selected entry.
REQ-007 Selection SHALL be oldest-first: the ready entry inserted earliest; ties impossible.
REQ-008 Issue occurs on a cycle with alu_valid && alu_ready; the selected entry SHALL be freed at that edge.
REQ-009 alu_* fields SHALL hold stable while alu_valid && !alu_ready unless an older entry becomes ready.
REQ-010 in_ready SHALL equal !full; it SHALL NOT depend on same-cycle issue.
REQ-011 Insert occurs on in_valid && in_ready; the entry SHALL be written into any free slot and marked youngest.
REQ-012 Inserted entry SHALL be issuable no earlier than the following cycle.
REQ-013 Wakeup: for each busy entry and each channel c with wb_en[c], qj==wb_q[c] (nonzero) SHALL set qj<=0, vj<=wb_v[c]; same for qk/vk.
REQ-014 Wakeup SHALL also apply to the entry being inserted that cycle (in_qj/in_qk compared against wb_q), so no broadcast is missed.
REQ-015 If several channels match one tag, the lowest-index channel SHALL supply the value.
REQ-016 Broadcast tag 0 SHALL never wake anything.
REQ-017 Entry woken at edge t SHALL be issuable in cycle t+1 (no same-cycle bypass to ALU).
REQ-018 Insert and issue in the same cycle SHALL both take effect; count changes by 0.
REQ-019 count SHALL be registered: +1 on insert only, -1 on issue only, unchanged otherwise; never exceeds DEPTH nor underflows.
REQ-020 flush=1 SHALL clear all busy bits and count at the edge, discarding same-cycle insert, issue, and wakeup; alu_valid SHALL still reflect pre-flush state that cycle.

Reset
REQ-021 rst==0 at an edge SHALL clear all busy bits, tags, age state and count, with priority over flush and all other inputs.
REQ-022 After reset: alu_valid=0, count=0, empty=1, full=0, in_ready=1; alu_* data fields=0.
REQ-023 Reset asserted mid-operation SHALL discard all entries and in-flight handshakes.

Verification
REQ-024 Insert op with qj=qk=0 at cycle 0, alu_ready=1 -> alu_valid=1 cycle 1 with matching fields; count 1 -> 0 after edge 1.
REQ-025 Insert A(qj=3), B(qj=0), C(qj=0) in order, alu_ready=0 -> alu_* shows B; broadcast tag 3 value 0x55 -> A issues first with alu_vs=0x55, then B, then C.
REQ-026 Fill DEPTH=8 entries with qj=5 -> full=1, in_ready=0, extra in_valid ignored; wb_en[1]=1, wb_q=5 -> all 8 ready, issue oldest-first, count reaches 0.
REQ-027 Insert qk=7 in same cycle as wb channel 0 tag 7 value 0x1234 -> entry issues next cycle with alu_vt=0x1234.
REQ-028 Queue 4 entries, flush with concurrent in_valid and issue -> count=0, empty=1, alu_valid=0 next cycle; repeat with rst=0 instead -> REQ-022 values.
